module_ctrl_spi_master: RTL and testbench
=========================================

Name: module_ctrl_spi_master

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) master sequencer. Drives SCLK and chip-select.
- Issues one-cycle load/shift strobes to the TX shift register and the RX shift register (module_rx_shift_reg_spi), which sit alongside it in the SPI interface.
- One start request produces one N_BITS-bit full-duplex frame, followed by a done pulse.

Parameters:
- HALF_PERIOD, 2, clk_i cycles per SCLK half-period (>=1).
- N_BITS, 8, bits per frame (>=1; matches the shift-register width).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-low.
- start_i  in  1  frame request; sampled only in IDLE.
- busy_o  out  1  high while a frame is in progress (any state except IDLE).
- done_o  out  1  one-cycle pulse when a frame completes.
- sclk_o  out  1  SPI clock, idles low.
- cs_o  out  1  chip select, active-low, idles high.
- tx_load_o  out  1  one-cycle pulse: TX register loads its parallel word.
- tx_shift_en_o  out  1  one-cycle pulse: TX register shifts the next bit out.
- rx_shift_en_o  out  1  one-cycle pulse: RX register captures MISO.
- bit_cnt_o  out  $clog2(N_BITS+1)  count of bits sampled so far in the current frame.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State goes to IDLE.
  - Outputs: busy_o=0, done_o=0, sclk_o=0, cs_o=1, all strobes 0, bit_cnt_o=0.
  - Divider counter and bit counter cleared.
  - Applies mid-frame with no partial completion and no done_o.
- All outputs are registered (Moore decode of the state register and counters). No combinational path from start_i to any output.
- States: IDLE, SETUP, HIGH, LOW, DONE. div_cnt counts 0..HALF_PERIOD-1 within each timed state.
- IDLE:
  - cs_o=1, sclk_o=0.
  - start_i=1 at an edge -> SETUP, div_cnt=0, bit_cnt=0.
- SETUP (HALF_PERIOD cycles):
  - cs_o=0, sclk_o=0.
  - tx_load_o=1 on the first cycle only, so MOSI bit N_BITS-1 is valid one half-period before the first rising SCLK.
  - At div_cnt=HALF_PERIOD-1 -> HIGH.
- HIGH (HALF_PERIOD cycles):
  - sclk_o=1, cs_o=0.
  - rx_shift_en_o=1 on the first cycle (coincident with the SCLK rising edge).
  - bit_cnt increments on that same edge.
  - At div_cnt=HALF_PERIOD-1 -> LOW.
- LOW (HALF_PERIOD cycles):
  - sclk_o=0, cs_o=0.
  - tx_shift_en_o=1 on the first cycle only if bit_cnt<N_BITS; suppressed after the last bit.
  - At div_cnt=HALF_PERIOD-1: -> HIGH if bit_cnt<N_BITS, else -> DONE.
- DONE (1 cycle):
  - cs_o=1, sclk_o=0, done_o=1, busy_o=1.
  - Next edge -> IDLE.
- Frame latency: busy_o high for HALF_PERIOD*(2*N_BITS+1)+1 cycles, which is 35 for the defaults. done_o asserts on the last busy cycle.
- Boundary conditions:
  - start_i while busy is ignored and not queued.
  - start_i held high re-triggers only from IDLE, so back-to-back frames have 1 IDLE cycle between DONE and SETUP, giving cs_o high for 2 cycles minimum.
  - HALF_PERIOD=1: every phase lasts 1 cycle and strobes coincide with the state entry cycle.
  - N_BITS=1: exactly one rx_shift_en_o and zero tx_shift_en_o pulses.
  - Counts per frame: exactly N_BITS rx_shift_en_o pulses, N_BITS-1 tx_shift_en_o pulses, and 1 tx_load_o pulse.
  - bit_cnt_o holds N_BITS through DONE and clears on the next SETUP entry.

Decomposition:
- pkg_spi:
  - typedef enum logic [2:0] spi_state_t {IDLE, SETUP, HIGH, LOW, DONE}.
  - Default constants SPI_N_BITS=8 and SPI_HALF_PERIOD=2, shared with the shift-register modules and benches.
- Sub-module: module_spi_phase_cnt, a half-period divider. Inputs are a clear and an enable; output is a registered terminal-count flag at HALF_PERIOD-1. The FSM and the bit counter stay in the top.

Test Plan:
- Reset then idle: rst_i=0 for 2 cycles, then 1, start_i=0 -> cs_o=1, sclk_o=0, busy_o=0, all strobes 0 indefinitely.
- Single frame, defaults: 1-cycle start_i pulse ->
  - tx_load_o on the cycle after start.
  - sclk_o shows 8 high pulses, each 2 cycles wide.
  - Exactly 8 rx_shift_en_o pulses (each on the first sclk_o=1 cycle) and 7 tx_shift_en_o pulses.
  - busy_o high for 35 cycles; done_o on cycle 35; cs_o low for exactly 34 cycles.
- Loopback: connect TX serial output to RX data_i, load 8'hA5 -> RX data_o=8'hA5 when done_o=1.
- start_i held high for 80 cycles -> two complete frames with 1 IDLE cycle between them; no extra strobes.
- Reset mid-frame: rst_i=0 after the 4th rx_shift_en_o -> next edge cs_o=1, sclk_o=0, busy_o=0, bit_cnt_o=0, no done_o. A new start then yields a full 8-bit frame.
- HALF_PERIOD=1, N_BITS=1: start pulse -> busy_o for 4 cycles, 1 rx strobe, 0 tx shift strobes, done_o on cycle 4.

Source files
------------

// File: rtl/module_ctrl_spi_master_pkg.sv
// pkg_spi: shared SPI state encoding and default frame/timing constants
package pkg_spi;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} spi_state_t;
  localparam int SPI_N_BITS = 8;
  localparam int SPI_HALF_PERIOD = 2;
endpackage

// File: rtl/module_ctrl_spi_master_if.sv
// module_ctrl_spi_master_if: request/status/strobe bundle of the SPI sequencer
// master: start_i in; busy_o, done_o, sclk_o, cs_o, tx_load_o, tx_shift_en_o,
//         rx_shift_en_o, bit_cnt_o out. slave: the mirror image.
interface module_ctrl_spi_master_if #(parameter int N_BITS = pkg_spi::SPI_N_BITS);
  logic start_i;
  logic busy_o;
  logic done_o;
  logic sclk_o;
  logic cs_o;
  logic tx_load_o;
  logic tx_shift_en_o;
  logic rx_shift_en_o;
  logic [$clog2(N_BITS+1)-1:0] bit_cnt_o;
  modport master(input start_i, output busy_o, done_o, sclk_o, cs_o, tx_load_o,
                 tx_shift_en_o, rx_shift_en_o, bit_cnt_o);
  modport slave(output start_i, input busy_o, done_o, sclk_o, cs_o, tx_load_o,
                tx_shift_en_o, rx_shift_en_o, bit_cnt_o);
endinterface

// File: rtl/module_ctrl_spi_master_phase_cnt.sv
// module_spi_phase_cnt: SCLK half-period divider with registered terminal count
// clk_i/rst_i (sync, active-low); clr_i restarts at 0; en_i advances;
// tc_o is high while the count sits at HALF_PERIOD-1.
module module_spi_phase_cnt #(
  parameter int HALF_PERIOD = pkg_spi::SPI_HALF_PERIOD
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);
  logic [W-1:0] cnt, nxt;
  assign nxt = tc_o ? '0 : cnt + 1'b1;
  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) begin
      cnt  <= '0;
      tc_o <= LAST == '0;
    end else if (en_i) begin
      cnt  <= nxt;
      tc_o <= nxt == LAST;
    end
  end
endmodule

// File: rtl/module_ctrl_spi_master.sv
// module_ctrl_spi_master: SPI mode-0 frame sequencer driving SCLK, CS and shift strobes
// clk_i: clock; rst_i: sync active-low reset; bus: start request in, status,
// SCLK/CS and one-cycle TX load/shift and RX capture strobes plus bit count out.
module module_ctrl_spi_master
  import pkg_spi::*;
#(
  parameter int HALF_PERIOD = SPI_HALF_PERIOD,
  parameter int N_BITS = SPI_N_BITS
) (
  input logic clk_i,
  input logic rst_i,
  module_ctrl_spi_master_if.master bus
);
  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] NB = CW'(N_BITS);
  spi_state_t state, nxt;
  logic first, tc, more;
  logic [CW-1:0] bit_cnt;
  assign more = bit_cnt < NB;
  // Every timed state lasts exactly one divider period, so the divider only
  // needs clearing outside frames and wraps in step with the state changes.
  module_spi_phase_cnt #(.HALF_PERIOD(HALF_PERIOD)) u_phase (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(state == IDLE || state == DONE),
    .en_i (1'b1),
    .tc_o (tc)
  );
  // first marks the entry cycle of a state; strobes fire only there.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      first   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state <= nxt;
      first <= nxt != state;
      if (state == IDLE && nxt == SETUP) bit_cnt <= '0;
      else if (nxt == HIGH && state != HIGH) bit_cnt <= bit_cnt + 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start_i ? SETUP : IDLE;
      SETUP:   nxt = tc ? HIGH : SETUP;
      HIGH:    nxt = tc ? LOW : HIGH;
      LOW:     nxt = tc ? (more ? HIGH : DONE) : LOW;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy_o        = state != IDLE;
    bus.done_o        = state == DONE;
    bus.sclk_o        = state == HIGH;
    bus.cs_o          = state == IDLE || state == DONE;
    bus.tx_load_o     = state == SETUP && first;
    bus.rx_shift_en_o = state == HIGH && first;
    bus.tx_shift_en_o = state == LOW && first && more;
    bus.bit_cnt_o     = bit_cnt;
  end
endmodule

// File: tb/tb_module_ctrl_spi_master.sv
// tb_module_ctrl_spi_master: directed self-checking bench for the SPI sequencer
module tb_module_ctrl_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  module_ctrl_spi_master_if bus();
  module_ctrl_spi_master_if #(.N_BITS(1)) bus1();

  module_ctrl_spi_master dut (.clk_i(clk), .rst_i(rst), .bus(bus.master));
  module_ctrl_spi_master #(.HALF_PERIOD(1), .N_BITS(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.master));

  logic [7:0] tx_word = 8'hA5;
  logic [7:0] tx_sr, rx_sr;
  always_ff @(posedge clk) begin
    if (bus.tx_load_o) tx_sr <= tx_word;
    else if (bus.tx_shift_en_o) tx_sr <= {tx_sr[6:0], 1'b0};
    if (bus.rx_shift_en_o) rx_sr <= {rx_sr[6:0], tx_sr[7]};
  end

  int total = 0, bad = 0;
  int n_busy, n_cs, n_rx, n_tx, n_load, n_sclk, n_rise, n_rx_al, n_done;
  int k_done, k_load, k_load_last, rx_at_done, cnt_at_done;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic watch(input int ncyc, input int hold);
    logic ps;
    ps = 1'b0;
    n_busy = 0; n_cs = 0; n_rx = 0; n_tx = 0; n_load = 0; n_sclk = 0;
    n_rise = 0; n_rx_al = 0; n_done = 0; k_done = 0; k_load = 0; k_load_last = 0;
    rx_at_done = -1; cnt_at_done = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      bus.start_i = (k < hold);
      if (bus.busy_o) n_busy++;
      if (!bus.cs_o) n_cs++;
      if (bus.rx_shift_en_o) n_rx++;
      if (bus.tx_shift_en_o) n_tx++;
      if (bus.sclk_o) n_sclk++;
      if (bus.sclk_o && !ps) n_rise++;
      if (bus.rx_shift_en_o && bus.sclk_o && !ps) n_rx_al++;
      if (bus.tx_load_o) begin
        n_load++;
        if (k_load == 0) k_load = k;
        k_load_last = k;
      end
      if (bus.done_o) begin
        n_done++;
        if (k_done == 0) k_done = k;
        rx_at_done = int'(rx_sr);
        cnt_at_done = int'(bus.bit_cnt_o);
      end
      ps = bus.sclk_o;
    end
  endtask

  initial begin
    int idle_bad, rxs, b1, r1, t1, l1, d1, kd1;
    bus.start_i = 1'b0;
    bus1.start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bitcnt", int'(bus.bit_cnt_o), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cs", int'(bus.cs_o), 1);
    chk("rst_sclk", int'(bus.sclk_o), 0);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    idle_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy_o || bus.sclk_o || !bus.cs_o || bus.tx_load_o || bus.tx_shift_en_o ||
          bus.rx_shift_en_o || bus.done_o) idle_bad++;
    end
    chk("idle_quiet", idle_bad, 0);

    // single frame, loopback 0xA5
    bus.start_i = 1'b1;
    watch(40, 0);
    chk("f1_busy", n_busy, 35);
    chk("f1_cs_low", n_cs, 34);
    chk("f1_rx", n_rx, 8);
    chk("f1_tx", n_tx, 7);
    chk("f1_load", n_load, 1);
    chk("f1_load_at", k_load, 1);
    chk("f1_sclk_high", n_sclk, 16);
    chk("f1_sclk_rise", n_rise, 8);
    chk("f1_rx_aligned", n_rx_al, 8);
    chk("f1_done", n_done, 1);
    chk("f1_done_at", k_done, 35);
    chk("f1_cnt_done", cnt_at_done, 8);
    chk("f1_loopback", rx_at_done, 'hA5);
    chk("f1_cnt_hold", int'(bus.bit_cnt_o), 8);

    // start held: two frames, one idle cycle between
    bus.start_i = 1'b1;
    watch(80, 72);
    chk("bb_busy", n_busy, 70);
    chk("bb_cs_low", n_cs, 68);
    chk("bb_rx", n_rx, 16);
    chk("bb_tx", n_tx, 14);
    chk("bb_load", n_load, 2);
    chk("bb_done", n_done, 2);
    chk("bb_done_at", k_done, 35);
    chk("bb_load2_at", k_load_last, 37);

    // reset after the 4th RX strobe
    tx_word = 8'h3C;
    bus.start_i = 1'b1;
    rxs = 0;
    for (int k = 0; k < 40 && rxs < 4; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.rx_shift_en_o) rxs++;
    end
    chk("mr_rx4", rxs, 4);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_cs", int'(bus.cs_o), 1);
    chk("mr_sclk", int'(bus.sclk_o), 0);
    chk("mr_busy", int'(bus.busy_o), 0);
    chk("mr_bitcnt", int'(bus.bit_cnt_o), 0);
    chk("mr_done", int'(bus.done_o), 0);
    rst = 1'b1;
    bus.start_i = 1'b1;
    watch(40, 0);
    chk("mr_f_busy", n_busy, 35);
    chk("mr_f_rx", n_rx, 8);
    chk("mr_f_tx", n_tx, 7);
    chk("mr_f_done_at", k_done, 35);
    chk("mr_f_loopback", rx_at_done, 'h3C);

    // HALF_PERIOD=1, N_BITS=1
    b1 = 0; r1 = 0; t1 = 0; l1 = 0; d1 = 0; kd1 = 0;
    bus1.start_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus1.start_i = 1'b0;
      if (bus1.busy_o) b1++;
      if (bus1.rx_shift_en_o) r1++;
      if (bus1.tx_shift_en_o) t1++;
      if (bus1.tx_load_o) l1++;
      if (bus1.done_o) begin
        d1++;
        kd1 = k;
      end
    end
    chk("s1_busy", b1, 4);
    chk("s1_rx", r1, 1);
    chk("s1_tx", t1, 0);
    chk("s1_load", l1, 1);
    chk("s1_done", d1, 1);
    chk("s1_done_at", kd1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
